fxp_accumulator: RTL and testbench

//  Downstream stage of the fixed-point multiplier: accepts signed Q(IN_I.IN_F) products

---
 rtl/fxp_pkg.sv | 30 +++
 rtl/fxp_accumulator_if.sv | 29 ++
 rtl/fxp_sat_add.sv | 24 ++
 rtl/fxp_accumulator.sv | 117 +++++++++++
 tb/tb_fxp_accumulator.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: Q-format widths, signed bounds and accumulator state encoding.
package fxp_pkg;

  function automatic int unsigned q_width(int unsigned i_bits, int unsigned f_bits);
    return i_bits + f_bits;
  endfunction

  // Raw-integer bounds of a signed Q(i.f) word.
  function automatic longint q_max(int unsigned i_bits, int unsigned f_bits);
    return (longint'(1) <<< (i_bits + f_bits - 1)) - 1;
  endfunction

  function automatic longint q_min(int unsigned i_bits, int unsigned f_bits);
    return -(longint'(1) <<< (i_bits + f_bits - 1));
  endfunction

  localparam int unsigned IN_I_DEF  = 5;
  localparam int unsigned IN_F_DEF  = 3;
  localparam int unsigned ACC_I_DEF = 8;
  localparam int unsigned ACC_F_DEF = 3;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  typedef enum logic {
    StAccum = ST_ACCUM,
    StHold  = ST_HOLD
  } acc_state_e;

endpackage

// File: rtl/fxp_accumulator_if.sv
// Input sample stream and output frame stream of the fixed-point accumulator.
interface fxp_accumulator_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_ovf;
  logic             in_unf;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;
  logic             out_ovf;
  logic             out_unf;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, in_ovf, in_unf, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_ovf, out_unf
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_ovf, in_unf, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_ovf, out_unf
  );
endinterface

// File: rtl/fxp_sat_add.sv
// Combinational signed saturating adder; sat_o flags a clamp to either bound.
module fxp_sat_add #(
  parameter int unsigned W = 11
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                sat_o
);
  logic [W:0] wide;

  always_comb begin
    wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // The two top bits disagree only when the true sum left the W-bit range.
    sat_o = wide[W] ^ wide[W-1];
    if (!sat_o) begin
      sum_o = wide[W-1:0];
    end else if (wide[W]) begin
      sum_o = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum_o = {1'b0, {(W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/fxp_accumulator.sv
// Sums LEN signed Q(IN_I.IN_F) samples into a saturating Q(ACC_I.ACC_F) frame sum with sticky flags.
module fxp_accumulator
  import fxp_pkg::*;
#(
  parameter int unsigned IN_I  = IN_I_DEF,
  parameter int unsigned IN_F  = IN_F_DEF,
  parameter int unsigned ACC_I = ACC_I_DEF,
  parameter int unsigned ACC_F = ACC_F_DEF,
  parameter int unsigned LEN   = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clear_i,
  fxp_accumulator_if.slave  bus
);
  localparam int unsigned ACC_W = q_width(ACC_I, ACC_F);
  localparam int unsigned SHIFT = ACC_F - IN_F;
  localparam int unsigned CNT_W = $clog2(LEN + 1);

  acc_state_e              state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        count_q;
  logic                    sat_q, ovf_q, unf_q;
  logic                    out_valid_q;
  logic [ACC_W-1:0]        out_data_q;
  logic                    out_sat_q, out_ovf_q, out_unf_q;

  logic signed [ACC_W-1:0] aligned;
  logic signed [ACC_W-1:0] sum;
  logic                    sum_sat;
  logic                    accept;
  logic                    last;

  // Sign-extend to the accumulator integer width, then line up the binary point.
  assign aligned = ACC_W'(signed'(bus.in_data)) <<< SHIFT;

  fxp_sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (aligned),
    .sum_o (sum),
    .sat_o (sum_sat)
  );

  assign bus.in_ready = (state_q == StAccum);
  assign accept       = bus.in_valid & (state_q == StAccum);
  assign last         = (count_q == CNT_W'(LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (clear_i) begin
      // Flush wins over any sample offered in the same cycle.
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            if (last) begin
              out_data_q  <= sum;
              out_sat_q   <= sat_q | sum_sat;
              out_ovf_q   <= ovf_q | bus.in_ovf;
              out_unf_q   <= unf_q | bus.in_unf;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              count_q     <= '0;
              sat_q       <= 1'b0;
              ovf_q       <= 1'b0;
              unf_q       <= 1'b0;
              state_q     <= StHold;
            end else begin
              acc_q   <= sum;
              count_q <= count_q + CNT_W'(1);
              sat_q   <= sat_q | sum_sat;
              ovf_q   <= ovf_q | bus.in_ovf;
              unf_q   <= unf_q | bus.in_unf;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;
endmodule

// File: tb/tb_fxp_accumulator.sv
// Directed bench: default Q5.3->Q8.3 instance plus an ACC_I=6 instance for saturation.
module tb_fxp_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_a = 1'b0;
  logic clear_b = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fxp_accumulator_if #(.IN_W(8), .ACC_W(11)) bus_a ();
  fxp_accumulator_if #(.IN_W(8), .ACC_W(9))  bus_b ();

  fxp_accumulator #(
    .IN_I (5), .IN_F (3), .ACC_I (8), .ACC_F (3), .LEN (4)
  ) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_a),
    .bus     (bus_a)
  );

  fxp_accumulator #(
    .IN_I (5), .IN_F (3), .ACC_I (6), .ACC_F (3), .LEN (4)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_b),
    .bus     (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic ovf, input logic unf);
    int g = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_ovf   = ovf;
    bus_a.in_unf   = unf;
    while (!bus_a.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("a_ready_timeout", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_ovf   = 1'b0;
    bus_a.in_unf   = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    int g = 0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    while (!bus_b.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("b_ready_timeout", 32'(bus_b.in_ready), 32'd1);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
  endtask

  task automatic release_a();
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_ovf = 1'b0;
    bus_a.in_unf = 1'b0;   bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_ovf = 1'b0;
    bus_b.in_unf = 1'b0;   bus_b.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus_a.out_data), 32'h0);
    chk("rst_out_flags", 32'({bus_a.out_sat, bus_a.out_ovf, bus_a.out_unf}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);

    // Frame 1.5 + 2.25 - 0.5 + 3.0 = 6.25
    push_a(8'h0C, 1'b0, 1'b0);
    push_a(8'h12, 1'b0, 1'b0);
    push_a(8'hFC, 1'b0, 1'b0);
    chk("t1_valid_early", 32'(bus_a.out_valid), 32'd0);
    push_a(8'h18, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus_a.out_valid), 32'd1);
    chk("t1_data", 32'(bus_a.out_data), 32'h032);
    chk("t1_sat", 32'(bus_a.out_sat), 32'd0);

    // Backpressure: sample waits while the frame is held
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_data", 32'(bus_a.out_data), 32'h032);
      chk("t3_hold_ready", 32'(bus_a.in_ready), 32'd0);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    chk("t3_valid_drop", 32'(bus_a.out_valid), 32'd0);
    chk("t3_ready_back", 32'(bus_a.in_ready), 32'd1);

    // Frame A: 2.0 + 1.0(ovf) - 1.0 + 0.5 = 2.5; held sample must count
    push_a(8'h10, 1'b0, 1'b0);
    push_a(8'h08, 1'b1, 1'b0);
    push_a(8'hF8, 1'b0, 1'b0);
    push_a(8'h04, 1'b0, 1'b0);
    chk("t4a_data", 32'(bus_a.out_data), 32'h014);
    chk("t4a_ovf", 32'(bus_a.out_ovf), 32'd1);
    chk("t4a_unf", 32'(bus_a.out_unf), 32'd0);
    release_a();

    // Frame B: sticky ovf must not leak; unf on last-but-one sample
    push_a(8'h08, 1'b0, 1'b0);
    push_a(8'h08, 1'b0, 1'b0);
    push_a(8'h08, 1'b0, 1'b1);
    push_a(8'h00, 1'b0, 1'b0);
    chk("t4b_data", 32'(bus_a.out_data), 32'h018);
    chk("t4b_ovf", 32'(bus_a.out_ovf), 32'd0);
    chk("t4b_unf", 32'(bus_a.out_unf), 32'd1);
    release_a();

    // Clear mid-frame drops partial sum, flags and the sample offered alongside
    push_a(8'h7F, 1'b1, 1'b0);
    push_a(8'h7F, 1'b1, 1'b0);
    clear_a = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h7F;
    @(negedge clk);
    clear_a = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("t5_clr_data", 32'(bus_a.out_data), 32'h0);
    chk("t5_clr_valid", 32'(bus_a.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) push_a(8'h08, 1'b0, 1'b0);
    chk("t5_data", 32'(bus_a.out_data), 32'h020);
    chk("t5_sat", 32'(bus_a.out_sat), 32'd0);
    chk("t5_ovf", 32'(bus_a.out_ovf), 32'd0);

    // Async reset while holding a frame
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t6_data", 32'(bus_a.out_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(bus_a.in_ready), 32'd1);

    // ACC_I=6: positive then negative saturation
    for (int i = 0; i < 4; i++) push_b(8'h7F);
    chk("t2_pos_data", 32'(bus_b.out_data), 32'h0FF);
    chk("t2_pos_sat", 32'(bus_b.out_sat), 32'd1);
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_b(8'h80);
    chk("t2_neg_data", 32'(bus_b.out_data), 32'h100);
    chk("t2_neg_sat", 32'(bus_b.out_sat), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
